// File: rtl/ifetch_seq_if.sv
// Instruction-memory fetch bus: request/address out of the fetch stage,
// ack/data back from instruction memory.
interface ifetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch stage side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_seq.sv
// ifetch_seq: multi-cycle instruction fetch stage.
// FETCH issues a word request at PC and waits for ack (bounded by
// TIMEOUT_CYCLES); EXEC presents Instruction/opcplus4 for exactly one cycle
// and then steps PC by jr / jump / branch / sequential priority; a fetch
// timeout parks the stage in a sticky ERR state that only reset leaves.
// Optional retired-instruction counter: define IFETCH_PERF_EN to build it,
// otherwise retired_cnt is tied to zero.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    ifetch_seq_if.master       imem,
    output logic [31:0]        Instruction,
    output logic [31:0]        opcplus4,
    output logic [31:0]        PC,
    output logic               instr_valid,
    input  logic [31:0]        Add_result,
    input  logic [31:0]        Read_data_1,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jrn,
    input  logic               Zero,
    output logic               fetch_err,
    output logic [31:0]        retired_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    // Counter value on which a still-missing ack turns into a timeout.
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_op4;
    logic        r_err;
    logic        w_take_br;
    logic [31:0] w_next_pc;

    // Next-PC select for the instruction currently in EXEC; jr beats
    // jump/jal, which beat a taken conditional branch.
    always_comb begin
        w_take_br = (Branch & Zero) | (nBranch & ~Zero);
        w_next_pc = r_op4;
        if (Jrn)
            w_next_pc = Read_data_1 & 32'hFFFF_FFFC;
        else if (Jmp || Jal)
            w_next_pc = {r_op4[31:28], r_instr[25:0], 2'b00};
        else if (w_take_br)
            w_next_pc = Add_result & 32'hFFFF_FFFC;
    end

    // Fetch/exec/error sequencer holding PC, the latched instruction and
    // the fetch timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 16'd0;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_op4   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        // An ack on the final count still completes the fetch.
                        r_instr <= imem.imem_rdata;
                        r_op4   <= r_pc + 32'd4;
                        r_cnt   <= 16'd0;
                        r_state <= S_EXEC;
                    end else if (r_cnt == LAST_CNT) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_EXEC: begin
                    r_pc    <= w_next_pc;
                    r_state <= S_FETCH;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    // Request drops combinationally under reset so an in-flight fetch is
    // abandoned in the reset cycle itself.
    assign imem.imem_req  = (r_state == S_FETCH) && !reset;
    assign imem.imem_addr = r_pc;
    assign instr_valid    = (r_state == S_EXEC);
    assign Instruction    = r_instr;
    assign opcplus4       = r_op4;
    assign PC             = r_pc;
    assign fetch_err      = r_err;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_retired;

    // Count each instruction leaving EXEC; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset)
            r_retired <= 32'd0;
        else if (r_state == S_EXEC)
            r_retired <= r_retired + 32'd1;
    end

    assign retired_cnt = r_retired;
`else
    assign retired_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: directed scenarios plus randomized
// control/latency traffic against a behavioural next-PC reference.
module tb_ifetch_seq;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 4;

    typedef struct packed {
        logic        br;
        logic        nbr;
        logic        jmp;
        logic        jal;
        logic        jrn;
        logic        zero;
        logic [31:0] add_res;
        logic [31:0] rd1;
    } ctl_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Instruction, opcplus4, PC, Add_result, Read_data_1, retired_cnt;
    logic        instr_valid, Branch, nBranch, Jmp, Jal, Jrn, Zero, fetch_err;

    ifetch_seq_if bus();

    ifetch_seq #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .imem(bus),
        .Instruction(Instruction), .opcplus4(opcplus4), .PC(PC),
        .instr_valid(instr_valid), .Add_result(Add_result),
        .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch),
        .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn), .Zero(Zero),
        .fetch_err(fetch_err), .retired_cnt(retired_cnt)
    );

    always #5 clock = ~clock;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_ret  = 0;
    logic [31:0] m_last_word;

    localparam ctl_t NONE = '0;

    function automatic logic [31:0] exp_ret();
`ifdef IFETCH_PERF_EN
        return m_ret;
`else
        return 32'd0;
`endif
    endfunction

    // Behavioural next-PC rules: arithmetic on byte addresses.
    function automatic logic [31:0] ref_next(input logic [31:0] op4, input logic [31:0] word, input ctl_t c);
        if (c.jrn) return c.rd1 - (c.rd1 % 4);
        if (c.jmp || c.jal) return (op4 & 32'hF000_0000) + (word % 32'h0400_0000) * 4;
        if (c.zero ? c.br : c.nbr) return c.add_res - (c.add_res % 4);
        return op4;
    endfunction

    task automatic set_ctl(input ctl_t c);
        Branch = c.br; nBranch = c.nbr; Jmp = c.jmp; Jal = c.jal; Jrn = c.jrn;
        Zero = c.zero; Add_result = c.add_res; Read_data_1 = c.rd1;
    endtask

    function automatic ctl_t jr_to(input logic [31:0] a);
        ctl_t c = '0;
        c.jrn = 1'b1; c.rd1 = a;
        return c;
    endfunction

    // One full instruction starting at a negedge inside FETCH; ends at the
    // negedge of the next FETCH.
    task automatic do_instr(input int dly, input logic [31:0] word, input ctl_t c);
        logic [31:0] op4, npc;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, m_pc}) $display("FAIL fetch_addr: req/addr %b/%h want 1/%h", bus.imem_req, bus.imem_addr, m_pc);
        else n_pass++;
        n_chk++;
        bus.imem_rdata = word;
        for (int i = 0; i < dly; i++) begin
            bus.imem_ack = 1'b0;
            @(negedge clock);
            if ({bus.imem_req, bus.imem_addr, instr_valid, fetch_err} !== {1'b1, m_pc, 1'b0, 1'b0})
                $display("FAIL fetch_wait: req/addr/valid/err %b/%h/%b/%b want 1/%h/0/0", bus.imem_req, bus.imem_addr, instr_valid, fetch_err, m_pc);
            else n_pass++;
            n_chk++;
        end
        bus.imem_ack = 1'b1;
        @(negedge clock);
        op4 = m_pc + 32'd4;
        if ({instr_valid, bus.imem_req} !== 2'b10) $display("FAIL exec_valid: valid/req %b/%b want 1/0", instr_valid, bus.imem_req);
        else n_pass++;
        n_chk++;
        if (Instruction !== word) $display("FAIL exec_instr: got %h want %h", Instruction, word);
        else n_pass++;
        n_chk++;
        if (opcplus4 !== op4) $display("FAIL exec_op4: got %h want %h", opcplus4, op4);
        else n_pass++;
        n_chk++;
        if (PC !== m_pc) $display("FAIL exec_pc: got %h want %h", PC, m_pc);
        else n_pass++;
        n_chk++;
        // ack/data noise during EXEC must be ignored
        bus.imem_ack   = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
        set_ctl(c);
        npc = ref_next(op4, word, c);
        @(negedge clock);
        bus.imem_ack = 1'b0;
        set_ctl(NONE);
        m_pc = npc;
        m_ret++;
        m_last_word = word;
        if ({instr_valid, retired_cnt} !== {1'b0, exp_ret()}) $display("FAIL retire: valid/cnt %b/%0d want 0/%0d", instr_valid, retired_cnt, exp_ret());
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; bus.imem_ack = 1'b0;
        @(negedge clock);
        if ({PC, Instruction, opcplus4} !== {RST_PC, 64'd0}) $display("FAIL reset_regs: pc/instr/op4 %h/%h/%h want %h/0/0", PC, Instruction, opcplus4, RST_PC);
        else n_pass++;
        n_chk++;
        if ({bus.imem_req, instr_valid, fetch_err, retired_cnt} !== 35'd0) $display("FAIL reset_flags: req/valid/err/cnt %b/%b/%b/%0d want 0/0/0/0", bus.imem_req, instr_valid, fetch_err, retired_cnt);
        else n_pass++;
        n_chk++;
        reset = 1'b0;
        m_pc = RST_PC; m_ret = 0;
        #1;
    endtask

    task automatic test_sequential();
        test_reset();
        for (int k = 0; k < 3; k++) begin
            do_instr(2, $urandom, NONE);
            if (bus.imem_addr !== 32'((k + 1) * 4)) $display("FAIL seq_addr: got %h want %h", bus.imem_addr, (k + 1) * 4);
            else n_pass++;
            n_chk++;
        end
    endtask

    task automatic test_branch();
        ctl_t c;
        do_instr(0, $urandom, NONE);          // 0xC -> 0x10
        c = '0; c.br = 1; c.zero = 1; c.add_res = 32'h40;
        do_instr(1, $urandom, c);
        if (bus.imem_addr !== 32'h40) $display("FAIL br_taken: got %h want 00000040", bus.imem_addr);
        else n_pass++;
        n_chk++;
        do_instr(0, $urandom, jr_to(32'h10));
        c.zero = 0;
        do_instr(3, $urandom, c);             // ack on the final timeout count
        if (bus.imem_addr !== 32'h14) $display("FAIL br_not_taken: got %h want 00000014", bus.imem_addr);
        else n_pass++;
        n_chk++;
        do_instr(0, $urandom, jr_to(32'h10));
        c = '0; c.nbr = 1; c.zero = 1; c.add_res = 32'h43;
        do_instr(2, $urandom, c);
        if (bus.imem_addr !== 32'h14) $display("FAIL nbr_not_taken: got %h want 00000014", bus.imem_addr);
        else n_pass++;
        n_chk++;
        do_instr(0, $urandom, jr_to(32'h10));
        c.zero = 0;
        do_instr(1, $urandom, c);
        if (bus.imem_addr !== 32'h40) $display("FAIL nbr_taken: got %h want 00000040", bus.imem_addr);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_jump_priority();
        ctl_t c;
        do_instr(0, $urandom, jr_to(32'h1000_0020));
        c = '0; c.jal = 1;
        do_instr(1, 32'h0C00_0100, c);
        if (bus.imem_addr !== 32'h1000_0400) $display("FAIL jal_target: got %h want 10000400", bus.imem_addr);
        else n_pass++;
        n_chk++;
        do_instr(0, $urandom, jr_to(32'h1000_0020));
        c = '0; c.jal = 1; c.jrn = 1; c.br = 1; c.zero = 1; c.add_res = 32'h80; c.rd1 = 32'h0000_0203;
        do_instr(0, 32'h0C00_0100, c);
        if (bus.imem_addr !== 32'h0000_0200) $display("FAIL jr_priority: got %h want 00000200", bus.imem_addr);
        else n_pass++;
        n_chk++;
        // opcplus4 wraps at the top of the address space
        do_instr(0, $urandom, jr_to(32'hFFFF_FFFF));
        do_instr(2, $urandom, NONE);
        if (bus.imem_addr !== 32'h0) $display("FAIL pc_wrap: got %h want 00000000", bus.imem_addr);
        else n_pass++;
        n_chk++;
    endtask

    task automatic test_random();
        ctl_t c;
        for (int k = 0; k < 60; k++) begin
            c.br = ($urandom_range(0, 3) == 0);
            c.nbr = ($urandom_range(0, 3) == 0);
            c.jmp = ($urandom_range(0, 5) == 0);
            c.jal = ($urandom_range(0, 5) == 0);
            c.jrn = ($urandom_range(0, 5) == 0);
            c.zero = 1'($urandom_range(0, 1));
            c.add_res = $urandom;
            c.rd1 = $urandom;
            do_instr($urandom_range(0, TMO - 1), $urandom, c);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] op4_hold;
        do_instr(1, 32'hA5A5_0001, jr_to(32'h300));
        op4_hold = m_pc;
        op4_hold = 32'h0;
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge clock);
            if ({fetch_err, bus.imem_req} !== 2'b01) $display("FAIL tmo_early: err/req %b/%b want 0/1", fetch_err, bus.imem_req);
            else n_pass++;
            n_chk++;
        end
        @(negedge clock);
        if ({fetch_err, bus.imem_req, instr_valid} !== 3'b100) $display("FAIL tmo_err: err/req/valid %b/%b/%b want 1/0/0", fetch_err, bus.imem_req, instr_valid);
        else n_pass++;
        n_chk++;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if ({fetch_err, bus.imem_req, instr_valid} !== 3'b100) $display("FAIL err_sticky: err/req/valid %b/%b/%b want 1/0/0", fetch_err, bus.imem_req, instr_valid);
            else n_pass++;
            n_chk++;
            if ({PC, Instruction, retired_cnt} !== {32'h300, m_last_word, exp_ret()}) $display("FAIL err_hold: pc/instr/cnt %h/%h/%0d want 00000300/%h/%0d", PC, Instruction, retired_cnt, m_last_word, exp_ret());
            else n_pass++;
            n_chk++;
        end
        bus.imem_ack = 1'b0;
        if (op4_hold !== 32'h0) $display("FAIL tmo_internal: %h", op4_hold);
        test_reset();
        do_instr(0, $urandom, NONE);
    endtask

    task automatic test_reset_midfetch();
        do_instr(1, 32'hCAFE_F00D, NONE);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
        #1;
        if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req);
        else n_pass++;
        n_chk++;
        @(negedge clock);
        if ({Instruction, opcplus4, PC, instr_valid} !== {64'd0, RST_PC, 1'b0}) $display("FAIL rst_discard: instr/op4/pc/valid %h/%h/%h/%b want 0/0/%h/0", Instruction, opcplus4, PC, instr_valid, RST_PC);
        else n_pass++;
        n_chk++;
        reset = 1'b0; bus.imem_ack = 1'b0;
        m_pc = RST_PC; m_ret = 0;
        #1;
        do_instr(0, $urandom, NONE);
    endtask

    task automatic test_perf();
        test_reset();
        for (int k = 0; k < 3; k++) do_instr($urandom_range(0, 2), $urandom, NONE);
`ifdef IFETCH_PERF_EN
        if (retired_cnt !== 32'd3) $display("FAIL perf_cnt: got %0d want 3", retired_cnt);
`else
        if (retired_cnt !== 32'd0) $display("FAIL perf_cnt: got %0d want 0", retired_cnt);
`endif
        else n_pass++;
        n_chk++;
    endtask

    initial begin
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        set_ctl(NONE);
        m_last_word = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_random();
        test_timeout();
        test_reset_midfetch();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Instruction fetch stage. Sits directly upstream of the register-file/decode stage.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents a registered Instruction and opcplus4 for one execute cycle, then computes the next PC from the branch, jump and jr controls.
- Multi-cycle: at least 2 clocks per instruction. A fetch timeout escalates to a sticky error state.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 255, FETCH cycles without imem_ack before entering ERR; legal range 1..65535.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request, high for the whole FETCH state.
- imem_addr  out  32  byte address of the fetch (= PC); stable while imem_req is high.
- imem_ack  in  1  rdata valid this cycle; sampled only in FETCH.
- imem_rdata  in  32  instruction word.
- Instruction  out  32  registered instruction to decode.
- opcplus4  out  32  registered PC+4 of the current Instruction; Jal link value.
- PC  out  32  address of the current Instruction.
- instr_valid  out  1  high only in EXEC; downstream must qualify RegWrite and memory writes with it.
- Add_result  in  32  branch target byte address from the ALU.
- Read_data_1  in  32  jr target from the register file.
- Branch, nBranch, Jmp, Jal, Jrn, Zero  in  1 each  control and ALU flag for the current instruction.
- fetch_err  out  1  sticky timeout flag.
- retired_cnt  out  32  instructions retired (see Optional Feature).

Behaviour:
Reset values (synchronous; wins over everything in the same cycle):
- PC=RESET_PC, Instruction=0, opcplus4=0, state=FETCH, timeout counter=0, fetch_err=0, retired_cnt=0.
- imem_req=0 during any cycle with reset high.

States: FETCH, EXEC, ERR.

FETCH:
- imem_req=1, imem_addr=PC, instr_valid=0.
- On a posedge with imem_ack=1: Instruction<=imem_rdata, opcplus4<=PC+4 (32-bit, wraps mod 2^32), counter<=0, go to EXEC.
- Zero-wait-state ack is legal: ack in the first req cycle gives EXEC next cycle.
- Otherwise counter++. When counter reaches TIMEOUT_CYCLES-1 and ack is still low: go to ERR, fetch_err<=1.
- An ack in the same cycle as the last count wins; no error is raised.

EXEC (exactly one cycle):
- instr_valid=1, imem_req=0. Instruction, opcplus4 and PC are stable.
- At the posedge: PC<=next_pc, go to FETCH. retired_cnt increments if enabled.

next_pc priority, highest first:
1. Jrn: {Read_data_1[31:2],2'b00}. Low bits are silently cleared.
2. Jmp or Jal: {opcplus4[31:28], Instruction[25:0], 2'b00}.
3. (Branch & Zero) | (nBranch & ~Zero): Add_result, with bits [1:0] forced to 0.
4. Otherwise: opcplus4.
- Simultaneous controls resolve strictly by this priority.

ERR:
- imem_req=0, instr_valid=0. Only reset exits.
- fetch_err stays 1; PC, Instruction and opcplus4 hold.

Other rules:
- imem_ack outside FETCH is ignored.
- Reset during FETCH abandons the outstanding request. An ack arriving in the reset cycle is discarded.
- No branch delay slot.
- Instruction memory must not change imem_rdata meaning for the requested address while imem_req is high.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: retired_cnt increments by 1 on every EXEC→FETCH edge and wraps from 32'hFFFF_FFFF to 0. It resets to 0 and holds in ERR.
- Not defined: the port is still present and tied to 32'h0; no counter flops are inferred.

Test Plan:
- Sequential fetch: reset release, RESET_PC=0, ack 2 cycles after req each time → imem_addr 0x0, 0x4, 0x8. opcplus4 is 0x4/0x8/0xC in each EXEC. instr_valid is high exactly one cycle per instruction.
- Taken branch: Instruction at PC=0x10, Branch=1, Zero=1, Add_result=0x40 → next imem_addr=0x40. Repeat with Zero=0 → next imem_addr=0x14. Same two cases with nBranch → inverse targets.
- Jump/jal/jr priority: PC=0x1000_0020, Instruction[25:0]=26'h0000100, Jal=1 → next PC=0x1000_0400 and opcplus4=0x1000_0024. Same cycle with Jrn=1, Read_data_1=0x0000_0203 → next PC=0x0000_0200.
- Timeout: TIMEOUT_CYCLES=4, imem_ack held 0 → fetch_err=1 after 4 FETCH cycles, imem_req=0 thereafter. Late ack ignored. Reset clears fetch_err, PC=RESET_PC.
- Reset mid-fetch: reset asserted in the cycle imem_ack=1 with rdata=0xDEADBEEF → Instruction=0, state FETCH, imem_req=0 that cycle, refetch of RESET_PC after release.
- Perf counter (IFETCH_PERF_EN): 3 instructions retired → retired_cnt=3. Without the macro, retired_cnt is 0 throughout.
